// File: rtl/gate_vector_sequencer_pkg.sv
// Shared definitions for the gate vector sequencer: FSM state encodings and
// the bit layout of one stored vector {A, B, expected F}.
package gate_vector_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int VEC_W = 3;
    localparam int VEC_A = 2;
    localparam int VEC_B = 1;
    localparam int VEC_F = 0;

endpackage

// File: rtl/gate_vector_sequencer_mem.sv
// gate_vec_mem: DEPTH x 3 vector store with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module gate_vec_mem
    import gate_vector_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [VEC_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [VEC_W-1:0]  rdata
);

    logic [VEC_W-1:0] mem [DEPTH];

    // Addresses beyond DEPTH (possible when DEPTH < 2**ADDR_W) are dropped on write
    // and read back as zero.
    always_ff @(posedge clock) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Applies stored {A,B,F} vectors to a 2-input gate, samples its output after a settle
// window and counts mismatches. Optional macro GATE_SEQ_STOP_ON_ERR_EN ends a run at the first mismatch.
module gate_vector_sequencer
    import gate_vector_sequencer_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [VEC_W-1:0]  load_data,
    output logic              dut_a,
    output logic              dut_b,
    input  logic              dut_f,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   vec_idx,
    output logic [ADDR_W-1:0] fail_idx
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] DEPTH_V = IDX_W'(DEPTH);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] clamp_depth(input logic [IDX_W-1:0] n);
        return (n > DEPTH_V) ? DEPTH_V : n;
    endfunction

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   num_vec_q;
    logic [IDX_W-1:0]   num_vec_clamped;
    logic [CNT_W-1:0]   settle_cnt;
    logic [VEC_W-1:0]   rd_data;
    logic               start_ok;
    logic               mismatch;
    logic               last_vec;

    gate_vec_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (load_we && !busy),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (vec_idx[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign num_vec_clamped = clamp_depth(num_vec);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch = (state == ST_CHECK) && (dut_f != rd_data[VEC_F]);
    assign last_vec = (vec_idx + IDX_W'(1)) >= num_vec_q;

    assign busy = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = (num_vec_clamped == '0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef GATE_SEQ_STOP_ON_ERR_EN
                state_nxt = (mismatch || last_vec) ? ST_DONE : ST_APPLY;
`else
                state_nxt = last_vec ? ST_DONE : ST_APPLY;
`endif
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Run registers: gate drive, settle window, entry index and error bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            err_count  <= '0;
            vec_idx    <= '0;
            fail_idx   <= '0;
            num_vec_q  <= '0;
            settle_cnt <= '0;
        end else begin
            if (start_ok) begin
                vec_idx   <= '0;
                err_count <= '0;
                fail_idx  <= '0;
                num_vec_q <= num_vec_clamped;
            end
            case (state)
                ST_APPLY: begin
                    dut_a      <= rd_data[VEC_A];
                    dut_b      <= rd_data[VEC_B];
                    settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count <= sat_inc(err_count);
                        if (err_count == '0) begin
                            fail_idx <= vec_idx[ADDR_W-1:0];
                        end
                    end
                    if (state_nxt == ST_APPLY) begin
                        vec_idx <= vec_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
